// File: rtl/assoc_cache.sv
// ============================================================================
// Module   : assoc_cache
// Brief    : Set-associative write-back cache with round-robin replacement.
//            Optional hit/miss counters enabled by defining CACHE_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module assoc_cache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int SET_BITS      = 5,
    parameter int BLOCK_SIZE    = 3,
    parameter int WAYS          = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req,
    input  logic                                 we,
    input  logic [ADDRESS_WIDTH-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 ready,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [ADDRESS_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] mem_wdata,
    input  logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0] mem_rdata,
    input  logic                                 mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                          hit_count,
    output logic [31:0]                          miss_count
`endif
);

    localparam int c_SETS   = 2**SET_BITS;
    localparam int c_TAG_W  = ADDRESS_WIDTH - SET_BITS - BLOCK_SIZE;
    localparam int c_LINE_W = DATA_WIDTH * (2**BLOCK_SIZE);
    localparam int c_PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_victim;
    logic [c_SETS-1:0]    r_valid [WAYS];
    logic [c_SETS-1:0]    r_dirty [WAYS];
    logic [c_TAG_W-1:0]   r_tag   [WAYS][c_SETS];
    logic [c_LINE_W-1:0]  r_data  [WAYS][c_SETS];

    logic [c_TAG_W-1:0]    w_tag;
    logic [SET_BITS-1:0]   w_set;
    logic [BLOCK_SIZE-1:0] w_off;
    logic                  w_hit;
    logic [c_PTR_W-1:0]    w_hit_way;
    logic                  w_inv_found;
    logic [c_PTR_W-1:0]    w_inv_way;
    logic [c_PTR_W-1:0]    w_ptr;
    logic [c_PTR_W-1:0]    w_victim;
    logic                  w_lookup;
    logic                  w_hit_cycle;
    logic                  w_miss_cycle;
    logic                  w_fill_done;
    logic [c_LINE_W-1:0]   w_hit_line;

    assign w_tag = addr[ADDRESS_WIDTH-1 -: c_TAG_W];
    assign w_set = addr[BLOCK_SIZE +: SET_BITS];
    assign w_off = addr[BLOCK_SIZE-1:0];

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w][w_set] && (r_tag[w][w_set] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_PTR_W'(w);
            end
            if (!r_valid[w][w_set]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_PTR_W'(w);
            end
        end
    end

    assign w_victim     = w_inv_found ? w_inv_way : w_ptr;
    assign w_lookup     = (r_state == IDLE) && req;
    assign w_hit_cycle  = w_lookup && w_hit;
    assign w_miss_cycle = w_lookup && !w_hit;
    assign w_fill_done  = (r_state == REFILL) && mem_ack;
    assign w_hit_line   = r_data[w_hit_way][w_set];

    assign ready     = w_hit_cycle;
    assign rdata     = w_hit_cycle ? w_hit_line[w_off*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign mem_req   = (r_state != IDLE);
    assign mem_we    = (r_state == WRITEBACK);
    assign mem_wdata = (r_state == WRITEBACK) ? r_data[r_victim][w_set] : '0;

    always_comb begin
        mem_addr = '0;
        if (r_state == WRITEBACK)
            mem_addr = {r_tag[r_victim][w_set], w_set, {BLOCK_SIZE{1'b0}}};
        else if (r_state == REFILL)
            mem_addr = {w_tag, w_set, {BLOCK_SIZE{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_victim <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss_cycle) begin
                        r_victim <= w_victim;
                        r_state  <= (r_valid[w_victim][w_set] && r_dirty[w_victim][w_set])
                                    ? WRITEBACK : REFILL;
                    end else if (w_hit_cycle && we) begin
                        r_dirty[w_hit_way][w_set] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack)
                        r_state <= REFILL;
                end
                REFILL: begin
                    if (mem_ack) begin
                        r_valid[r_victim][w_set] <= 1'b1;
                        r_dirty[r_victim][w_set] <= 1'b0;
                        r_state                  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_hit_cycle && we) begin
            r_data[w_hit_way][w_set][w_off*DATA_WIDTH +: DATA_WIDTH] <= wdata;
        end else if (w_fill_done) begin
            r_data[r_victim][w_set] <= mem_rdata;
            r_tag[r_victim][w_set]  <= w_tag;
        end
    end

    generate
        if (WAYS > 1) begin : g_ptr
            logic [c_PTR_W-1:0] r_ptr [c_SETS];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < c_SETS; s++)
                        r_ptr[s] <= '0;
                end else if (w_fill_done) begin
                    r_ptr[w_set] <= r_ptr[w_set] + 1'b1;
                end
            end
            assign w_ptr = r_ptr[w_set];
        end else begin : g_no_ptr
            assign w_ptr = '0;
        end
    endgenerate

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_cycle && (r_hit_count != '1))
                r_hit_count <= r_hit_count + 32'd1;
            if (w_miss_cycle && (r_miss_count != '1))
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_assoc_cache.sv
// Testbench for assoc_cache: directed scenarios plus randomized accesses
// checked against a word-level memory model and a per-set residency model.
`default_nettype none

module tb_assoc_cache;

    localparam int WAYS = 2;
    localparam int SETS = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [29:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         ready;
    logic         mem_req;
    logic         mem_we;
    logic [29:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    assoc_cache dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural memory (latest written words) and backing memory.
    bit [31:0] gmem [int];
    bit [31:0] bmem [int];
    bit        m_v [WAYS][SETS];
    bit        m_d [WAYS][SETS];
    int        m_t [WAYS][SETS];
    int        m_p [SETS];

    function automatic bit [31:0] init_word(int a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic bit [31:0] g_word(int a);
        return gmem.exists(a) ? gmem[a] : init_word(a);
    endfunction

    function automatic bit [31:0] b_word(int a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [255:0] g_line(int base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = g_word(base + i);
        return l;
    endfunction

    function automatic logic [255:0] b_line(int base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = b_word(base + i);
        return l;
    endfunction

    function automatic int m_find(int a);
        int s = (a >> 3) % SETS;
        for (int w = 0; w < WAYS; w++)
            if (m_v[w][s] && m_t[w][s] == (a >> 8)) return w;
        return -1;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_v[w][s] = 0;
                m_d[w][s] = 0;
            end
        for (int s = 0; s < SETS; s++) m_p[s] = 0;
        gmem.delete();
        foreach (bmem[k]) gmem[k] = bmem[k];
    endtask

    task automatic access(input bit wr, input int a, input bit [31:0] d, input int lw, input int lr);
        int way, s, vic, start, exp_lat, base, vbase;
        bit wb;
        s    = (a >> 3) % SETS;
        base = a & ~7;
        @(negedge clk);
        req = 1'b1; we = wr; addr = a[29:0]; wdata = d;
        start = cyc;
        #1;
        way = m_find(a);
        if (way < 0) begin
            check("miss_ready", ready, 0);
            vic = -1;
            for (int w = 0; w < WAYS; w++) if (!m_v[w][s] && vic < 0) vic = w;
            if (vic < 0) vic = m_p[s];
            wb = m_v[vic][s] && m_d[vic][s];
            exp_lat = 2 + lr + (wb ? 1 + lw : 0);
            if (wb) begin
                vbase = (m_t[vic][s] << 8) | (s << 3);
                @(negedge clk); #1;
                check("wb_req_we", {mem_req, mem_we}, 2'b11);
                check("wb_addr", mem_addr, vbase);
                check("wb_data", mem_wdata, g_line(vbase));
                repeat (lw) @(negedge clk);
                mem_ack = 1'b1;
                for (int i = 0; i < 8; i++) bmem[vbase + i] = g_word(vbase + i);
                @(posedge clk); #1 mem_ack = 1'b0;
            end
            @(negedge clk); #1;
            check("rf_req_we", {mem_req, mem_we}, 2'b10);
            check("rf_addr", mem_addr, base);
            repeat (lr) @(negedge clk);
            mem_rdata = b_line(base);
            mem_ack   = 1'b1;
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            m_v[vic][s] = 1; m_d[vic][s] = 0; m_t[vic][s] = a >> 8;
            m_p[s] = (m_p[s] + 1) % WAYS;
            way = vic;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); #1;
                if (ready) break;
            end
            check("latency", cyc - start, exp_lat);
        end
        check("hit_ready", ready, 1);
        check("hit_idle_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
        if (!wr) check("rdata", rdata, g_word(a));
        @(posedge clk);
        if (wr) begin
            gmem[a] = d;
            m_d[way][s] = 1;
        end
        #1 req = 1'b0; we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        check("rst_outputs", {ready, rdata, mem_req, mem_we, mem_addr, mem_wdata}, '0);
        @(negedge clk); rst_n = 1'b1;

        // Basic clean miss, then write hit and read-back.
        bmem[32'h100] = 32'hDEADBEEF;
        gmem[32'h100] = 32'hDEADBEEF;
        access(0, 32'h100, 0, 0, 1);
        access(1, 32'h101, 32'h12345678, 0, 0);
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 2);
        check("miss_count", miss_count, 1);
`endif
        access(0, 32'h101, 0, 0, 0);

        // Set-0 conflict: 0x300 must evict dirty 0x100.
        access(0, 32'h200, 0, 0, 0);
        access(0, 32'h300, 0, 1, 2);
        check("evicted_line_mem", bmem[32'h101], 32'h12345678);

        // Stray mem_ack in IDLE is ignored.
        @(negedge clk); mem_ack = 1'b1; #1;
        check("stray_ack_now", {ready, mem_req, rdata}, '0);
        @(negedge clk); mem_ack = 1'b0; #1;
        check("stray_ack_after", {ready, mem_req, mem_addr}, '0);
        access(0, 32'h300, 0, 0, 0);

        // Reset asserted during REFILL with mem_ack pending.
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 30'h480; #1;
        check("abort_miss", ready, 0);
        @(negedge clk); #1;
        check("abort_refill_req", mem_req, 1);
        mem_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_req", {mem_req, mem_we, mem_addr, mem_wdata, ready}, '0);
        @(posedge clk); #1 mem_ack = 1'b0; req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        access(0, 32'h480, 0, 0, 0);
        access(0, 32'h101, 0, 0, 0);

        // Randomized traffic over a few tags per set to force conflicts.
        for (int n = 0; n < 200; n++) begin
            int a;
            a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7);
            access($urandom_range(0, 1), a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
